// File: rtl/arrow_stream_writer.sv
// Game-side arrow scroller: shifts the 26-slot arrow field one slot per step, loads new
// arrows from the chart feed, judges both players' presses and runs the start/drain/done FSM.
module arrow_stream_writer #(
  parameter int TICK_DIV       = 3125000,
  parameter int HIT_FIRST      = 23,
  parameter int HIT_CENTER     = 24,
  parameter int HIT_LAST       = 25,
  parameter int INDICATOR_HOLD = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        chart_done,
  input  logic [2:0]  next_arrow,
  input  logic        next_valid,
  output logic        next_ready,
  input  logic [2:0]  p1_press,
  input  logic [2:0]  p2_press,
  output logic [77:0] arrow_array,
  output logic [1:0]  p1_indicator,
  output logic [1:0]  p2_indicator,
  output logic        step,
  output logic        finished
);

  localparam int SLOTS  = 26;
  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(INDICATOR_HOLD + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(INDICATOR_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  localparam logic [1:0] IND_NONE = 2'b00;
  localparam logic [1:0] IND_BAD  = 2'b01;
  localparam logic [1:0] IND_GOOD = 2'b10;
  localparam logic [1:0] IND_EXC  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div;
  logic [SLOTS-1:0]    claim     [2];
  logic [SLOTS-1:0]    claim_nxt [2];
  logic [1:0]          ind       [2];
  logic [1:0]          ind_nxt   [2];
  logic [HOLD_W-1:0]   hold      [2];
  logic [HOLD_W-1:0]   hold_nxt  [2];
  logic [2:0]          press     [2];
  int                  hit_pos   [2];
  logic                active;
  logic [2:0]          slot0_new;
  logic [3*SLOTS-1:0]  shifted;

  // Unused codes 101/111 enter the field as empty slots.
  function automatic logic [2:0] clean_code(input logic [2:0] c);
    return (c == 3'b101 || c == 3'b111) ? 3'b000 : c;
  endfunction

  // Returns the slot an unclaimed matching arrow sits in, centre first, or -1.
  function automatic int find_slot(input logic [3*SLOTS-1:0] arr,
                                   input logic [SLOTS-1:0] cl,
                                   input logic [2:0] code);
    int r;
    r = -1;
    if (!cl[HIT_CENTER] && arr[3*HIT_CENTER +: 3] == code)
      r = HIT_CENTER;
    else if (!cl[HIT_LAST] && arr[3*HIT_LAST +: 3] == code)
      r = HIT_LAST;
    else if (!cl[HIT_FIRST] && arr[3*HIT_FIRST +: 3] == code)
      r = HIT_FIRST;
    return r;
  endfunction

  assign active     = (state == S_RUN) || (state == S_DRAIN);
  assign step       = active && (div == DIV_LAST);
  assign next_ready = step && (state == S_RUN) && !chart_done;
  assign slot0_new  = (next_ready && next_valid) ? clean_code(next_arrow) : 3'b000;
  assign shifted    = {arrow_array[3*SLOTS-4:0], slot0_new};
  assign press[0]   = p1_press;
  assign press[1]   = p2_press;
  assign finished   = (state == S_DONE);
  assign p1_indicator = ind[0];
  assign p2_indicator = ind[1];

  // Per-player judging: decay, then miss, then press; later events overwrite earlier ones.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit_pos[p]   = find_slot(arrow_array, claim[p], press[p]);
      claim_nxt[p] = step ? {claim[p][SLOTS-2:0], 1'b0} : claim[p];
      ind_nxt[p]   = ind[p];
      hold_nxt[p]  = hold[p];
      if (step && hold[p] != '0) begin
        hold_nxt[p] = hold[p] - 1'b1;
        if (hold[p] == HOLD_ONE)
          ind_nxt[p] = IND_NONE;
      end
      if (step && arrow_array[3*SLOTS-1 -: 3] != 3'b000 && !claim[p][SLOTS-1]) begin
        ind_nxt[p]  = IND_BAD;
        hold_nxt[p] = HOLD_LOAD;
      end
      if (active && press[p] != 3'b000) begin
        hold_nxt[p] = HOLD_LOAD;
        if (hit_pos[p] < 0) begin
          ind_nxt[p] = IND_BAD;
        end else begin
          ind_nxt[p] = (hit_pos[p] == HIT_CENTER) ? IND_EXC : IND_GOOD;
          // A claim riding the step moves with its arrow; past the last slot it falls off.
          claim_nxt[p] = claim_nxt[p] | (26'd1 << (hit_pos[p] + (step ? 1 : 0)));
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      div         <= '0;
      arrow_array <= '0;
      for (int p = 0; p < 2; p++) begin
        claim[p] <= '0;
        ind[p]   <= IND_NONE;
        hold[p]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RUN;
            div         <= '0;
            arrow_array <= '0;
            for (int p = 0; p < 2; p++) begin
              claim[p] <= '0;
              ind[p]   <= IND_NONE;
              hold[p]  <= '0;
            end
          end
        end
        S_RUN, S_DRAIN: begin
          div <= step ? '0 : div + 1'b1;
          for (int p = 0; p < 2; p++) begin
            claim[p] <= claim_nxt[p];
            ind[p]   <= ind_nxt[p];
            hold[p]  <= hold_nxt[p];
          end
          if (step) begin
            arrow_array <= shifted;
            if (state == S_RUN && chart_done)
              state <= S_DRAIN;
            else if (state == S_DRAIN && shifted == '0)
              state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arrow_stream_writer.sv
// Scoreboard bench for arrow_stream_writer: a slot-list game model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_arrow_stream_writer;
  localparam int TICK = 4;
  localparam int HOLD = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

  logic        clock = 1'b0;
  logic        resetn, start, chart_done, next_valid, next_ready, step, finished;
  logic [2:0]  next_arrow, p1_press, p2_press;
  logic [77:0] arrow_array;
  logic [1:0]  p1_indicator, p2_indicator;

  always #5 clock = ~clock;

  arrow_stream_writer #(.TICK_DIV(TICK), .INDICATOR_HOLD(HOLD)) dut (
    .clock(clock), .resetn(resetn), .start(start), .chart_done(chart_done),
    .next_arrow(next_arrow), .next_valid(next_valid), .next_ready(next_ready),
    .p1_press(p1_press), .p2_press(p2_press), .arrow_array(arrow_array),
    .p1_indicator(p1_indicator), .p2_indicator(p2_indicator),
    .step(step), .finished(finished)
  );

  typedef struct {
    logic [77:0] arr;
    logic [1:0]  i1, i2;
    logic        stp, rdy, fin;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0, checks = 0, cyc = 0;

  // Desired level inputs, applied just after the next rising edge.
  logic       rst_d = 1'b0, cd_d = 1'b0, nv_d = 1'b0;
  logic [2:0] na_d = 3'b000;

  // Reference game model
  int m_st, m_div;
  int m_slot [26];
  bit m_claim [2][26];
  int m_ind [2], m_hold [2];
  bit m_xfer;

  function automatic int cln(int a);
    return (a == 5 || a == 7) ? 0 : a;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE;
    m_div = 0;
    for (int k = 0; k < 26; k++) begin
      m_slot[k] = 0;
      m_claim[0][k] = 0;
      m_claim[1][k] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      m_ind[p] = 0;
      m_hold[p] = 0;
    end
  endtask

  task automatic model_eval();
    exp_t e;
    bit stp, rdy, all_zero;
    bit miss [2];
    int res [2], pos [2], order [3];
    logic [2:0] pr [2];
    int tgt;
    if (!resetn) model_reset();
    stp = (m_st == S_RUN || m_st == S_DRAIN) && m_div == TICK - 1;
    rdy = stp && m_st == S_RUN && !chart_done;
    e.arr = '0;
    for (int k = 0; k < 26; k++) e.arr[3*k +: 3] = 3'(m_slot[k]);
    e.i1 = 2'(m_ind[0]);
    e.i2 = 2'(m_ind[1]);
    e.stp = stp;
    e.rdy = rdy;
    e.fin = (m_st == S_DONE);
    e.cyc = cyc;
    sbq.push_back(e);
    cyc++;
    m_xfer = rdy && next_valid;
    if (!resetn) return;
    if (m_st == S_IDLE || m_st == S_DONE) begin
      if (start) begin
        model_reset();
        m_st = S_RUN;
      end
      return;
    end
    pr[0] = p1_press;
    pr[1] = p2_press;
    order = '{24, 25, 23};
    for (int p = 0; p < 2; p++) begin
      res[p] = 0;
      pos[p] = -1;
      miss[p] = stp && m_slot[25] != 0 && !m_claim[p][25];
      if (pr[p] != 0) begin
        for (int j = 0; j < 3; j++)
          if (pos[p] < 0 && m_slot[order[j]] == int'(pr[p]) && !m_claim[p][order[j]])
            pos[p] = order[j];
        res[p] = (pos[p] < 0) ? 1 : ((pos[p] == 24) ? 3 : 2);
      end
    end
    if (stp) begin
      for (int k = 25; k > 0; k--) begin
        m_slot[k] = m_slot[k-1];
        m_claim[0][k] = m_claim[0][k-1];
        m_claim[1][k] = m_claim[1][k-1];
      end
      m_slot[0] = (rdy && next_valid) ? cln(int'(next_arrow)) : 0;
      m_claim[0][0] = 0;
      m_claim[1][0] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (pos[p] >= 0) begin
        tgt = pos[p] + (stp ? 1 : 0);
        if (tgt <= 25) m_claim[p][tgt] = 1;
      end
      if (stp && m_hold[p] > 0) begin
        m_hold[p]--;
        if (m_hold[p] == 0) m_ind[p] = 0;
      end
      if (miss[p]) begin
        m_ind[p] = 1;
        m_hold[p] = HOLD;
      end
      if (res[p] != 0) begin
        m_ind[p] = res[p];
        m_hold[p] = HOLD;
      end
    end
    if (stp) begin
      all_zero = 1;
      for (int k = 0; k < 26; k++) if (m_slot[k] != 0) all_zero = 0;
      if (m_st == S_RUN && chart_done) m_st = S_DRAIN;
      else if (m_st == S_DRAIN && all_zero) m_st = S_DONE;
    end
    m_div = stp ? 0 : m_div + 1;
  endtask

  task automatic cycle(input bit s, input logic [2:0] a, input logic [2:0] b);
    @(posedge clock);
    #1;
    resetn = rst_d;
    chart_done = cd_d;
    next_valid = nv_d;
    next_arrow = na_d;
    start = s;
    p1_press = a;
    p2_press = b;
    model_eval();
  endtask

  task automatic fresh_game(input logic [2:0] code);
    rst_d = 1'b0;
    cycle(0, 0, 0);
    rst_d = 1'b1;
    cd_d = 1'b0;
    nv_d = 1'b1;
    na_d = code;
    cycle(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0);
      if (m_xfer) break;
    end
    nv_d = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [77:0] got, input logic [77:0] exp, input int c);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("arrow_array", arrow_array, e.arr, e.cyc);
        chk("p1_indicator", 78'(p1_indicator), 78'(e.i1), e.cyc);
        chk("p2_indicator", 78'(p2_indicator), 78'(e.i2), e.cyc);
        chk("step", 78'(step), 78'(e.stp), e.cyc);
        chk("next_ready", 78'(next_ready), 78'(e.rdy), e.cyc);
        chk("finished", 78'(finished), 78'(e.fin), e.cyc);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin : driver
    int r;
    logic [2:0] pa, pb;
    resetn = 1'b0; start = 1'b0; chart_done = 1'b0; next_valid = 1'b0;
    next_arrow = 3'b000; p1_press = 3'b000; p2_press = 3'b000;
    model_reset();
    repeat (3) cycle(0, 0, 0);
    rst_d = 1'b1;
    // Presses while idle must leave everything untouched.
    cycle(0, 3'b010, 3'b001);
    cycle(0, 3'b001, 3'b110);
    // Continuous feed of up-arrows.
    nv_d = 1'b1; na_d = 3'b001;
    cycle(1, 0, 0);
    repeat (14) cycle(0, 0, 0);
    // Single left arrow judged at the centre, then re-pressed once claimed.
    fresh_game(3'b010);
    for (int i = 0; i < 200 && m_slot[24] != 2; i++) cycle(0, 0, 0);
    cycle(0, 3'b010, 0);
    cycle(0, 3'b010, 0);
    repeat (24) cycle(0, 0, 0);
    // Right arrow hit at the first target slot on the step cycle.
    fresh_game(3'b100);
    for (int i = 0; i < 200; i++) begin
      if (m_slot[23] == 4 && m_div == TICK - 1) begin
        cycle(0, 0, 3'b100);
        break;
      end
      cycle(0, 0, 0);
    end
    repeat (16) cycle(0, 0, 0);
    cycle(0, 3'b011, 0);
    repeat (2) cycle(0, 0, 0);
    cycle(0, 3'b101, 3'b101);
    repeat (12) cycle(0, 0, 0);
    // Drain with a lone arrow at slot 20, then restart.
    fresh_game(3'b011);
    for (int i = 0; i < 200 && m_slot[20] == 0; i++) cycle(0, 0, 0);
    cd_d = 1'b1;
    repeat (40) cycle(0, 0, 0);
    cd_d = 1'b0;
    cycle(1, 0, 0);
    repeat (10) cycle(0, 0, 0);
    // Asynchronous reset in the middle of a drain.
    nv_d = 1'b1; na_d = 3'b001;
    repeat (20) cycle(0, 0, 0);
    cd_d = 1'b1;
    repeat (10) cycle(0, 0, 0);
    rst_d = 1'b0;
    repeat (2) cycle(0, 0, 0);
    rst_d = 1'b1; cd_d = 1'b0; nv_d = 1'b0;
    repeat (10) cycle(0, 3'b001, 0);
    cycle(1, 0, 0);
    repeat (10) cycle(0, 0, 0);
    // Randomised play.
    for (int n = 0; n < 4000; n++) begin
      nv_d = ($urandom_range(0, 3) != 0);
      na_d = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) cd_d = ~cd_d;
      rst_d = ($urandom_range(0, 1499) != 0);
      r = $urandom_range(0, 9);
      pa = (r < 6) ? 3'b000 : (r < 8) ? 3'($urandom_range(0, 7)) : 3'(m_slot[$urandom_range(23, 25)]);
      r = $urandom_range(0, 9);
      pb = (r < 6) ? 3'b000 : (r < 8) ? 3'($urandom_range(0, 7)) : 3'(m_slot[$urandom_range(23, 25)]);
      cycle($urandom_range(0, 39) == 0, pa, pb);
    end
    @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d left required=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
